port_sel_remap_vc: RTL and testbench

Registered, multi-lane successor to the combinational port-number-to-port-select correction. Each VC lane accepts a global output-port number (0..PORT_NUM-1). The lane drops the router's own port (SWITCH_LOCATION) and produces the compacted crossbar select index in both binary and one-hot form, behind a 1-deep valid/ready register stage. Illegal requests (U-turn to own port, or out-of-range port number) are trapped, flagged and counted rather than forwarded. The block sits between route computation and switch-allocator request generation in the VC router.

---
 rtl/port_sel_remap_vc_pkg.sv | 18 +
 rtl/port_sel_remap_vc_if.sv | 38 +++
 rtl/port_sel_remap_vc_lane.sv | 93 +++++++++
 rtl/port_sel_remap_vc.sv | 97 +++++++++
 tb/tb_port_sel_remap_vc.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/port_sel_remap_vc_pkg.sv
// Shared helpers for the port-select remap block: derived width math for the
// port-number and compacted-select fields.
package port_sel_remap_vc_pkg;

  // ceil(log2(n)) with a floor of 1 so a 2-entry space still gets a bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

  function automatic int unsigned port_num_w(input int unsigned port_num);
    return clog2_min1(port_num);
  endfunction

  function automatic int unsigned port_sel_w(input int unsigned port_num);
    return clog2_min1(port_num - 32'd1);
  endfunction

endpackage : port_sel_remap_vc_pkg

// File: rtl/port_sel_remap_vc_if.sv
// Request/result/error bundle between route computation (master) and the
// port-select remap stage (slave). Lane i uses slice [i*W +: W] of each bus.
interface port_sel_remap_vc_if
  import port_sel_remap_vc_pkg::*;
#(
  parameter int unsigned PORT_NUM        = 5,
  parameter int unsigned VC_NUM_PER_PORT = 2,
  parameter int unsigned ERR_CNT_WIDTH   = 8
);
  localparam int unsigned PNW = port_num_w(PORT_NUM);
  localparam int unsigned PSW = port_sel_w(PORT_NUM);
  localparam int unsigned OHW = PORT_NUM - 1;

  logic [VC_NUM_PER_PORT-1:0]     in_valid;
  logic [VC_NUM_PER_PORT-1:0]     in_ready;
  logic [VC_NUM_PER_PORT*PNW-1:0] in_port_num_bcd;
  logic [VC_NUM_PER_PORT-1:0]     out_valid;
  logic [VC_NUM_PER_PORT-1:0]     out_ready;
  logic [VC_NUM_PER_PORT*PSW-1:0] out_port_sel_bcd;
  logic [VC_NUM_PER_PORT*OHW-1:0] out_port_sel_one_hot;
  logic [VC_NUM_PER_PORT-1:0]     err_illegal;
  logic [VC_NUM_PER_PORT-1:0]     err_sticky;
  logic                           err_clr;
  logic [ERR_CNT_WIDTH-1:0]       err_cnt;

  modport master (
    output in_valid, in_port_num_bcd, out_ready, err_clr,
    input  in_ready, out_valid, out_port_sel_bcd, out_port_sel_one_hot,
           err_illegal, err_sticky, err_cnt
  );

  modport slave (
    input  in_valid, in_port_num_bcd, out_ready, err_clr,
    output in_ready, out_valid, out_port_sel_bcd, out_port_sel_one_hot,
           err_illegal, err_sticky, err_cnt
  );

endinterface : port_sel_remap_vc_if

// File: rtl/port_sel_remap_vc_lane.sv
// One VC lane: drops SWITCH_LOCATION from the port space, traps U-turn and
// out-of-range requests, and holds the result in a 1-deep valid/ready stage.
module port_sel_remap_vc_lane
  import port_sel_remap_vc_pkg::*;
#(
  parameter  int unsigned PORT_NUM        = 5,
  parameter  int unsigned SWITCH_LOCATION = 0,
  localparam int unsigned PNW             = port_num_w(PORT_NUM),
  localparam int unsigned PSW             = port_sel_w(PORT_NUM),
  localparam int unsigned OHW             = PORT_NUM - 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid_i,
  input  logic [PNW-1:0] in_port_i,
  input  logic           out_ready_i,
  input  logic           err_clr_i,
  output logic           in_ready_c_o,
  output logic           illegal_acc_c_o,
  output logic           out_valid_o,
  output logic [PSW-1:0] out_sel_o,
  output logic [OHW-1:0] out_one_hot_o,
  output logic           err_illegal_o,
  output logic           err_sticky_o
);

  logic           out_valid_q, out_valid_d;
  logic [PSW-1:0] sel_q, sel_d;
  logic [OHW-1:0] one_hot_q, one_hot_d;
  logic           err_pulse_q, err_pulse_d;
  logic           sticky_q, sticky_d;

  logic           in_ready_c;
  logic           accept_c;
  logic           illegal_c;
  logic [PSW-1:0] map_sel_c;

  assign in_ready_c = ~out_valid_q | out_ready_i;
  assign accept_c   = in_valid_i & in_ready_c;

  // Ports above our own slot shift down by one to close the gap
  always_comb begin
    illegal_c = (in_port_i == PNW'(SWITCH_LOCATION)) || (32'(in_port_i) >= PORT_NUM);
    map_sel_c = (32'(in_port_i) > SWITCH_LOCATION) ? PSW'(32'(in_port_i) - 32'd1)
                                                   : PSW'(in_port_i);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    one_hot_d   = one_hot_q;
    err_pulse_d = accept_c & illegal_c;
    sticky_d    = sticky_q & ~err_clr_i;

    if (accept_c && !illegal_c) begin
      out_valid_d = 1'b1;
      sel_d       = map_sel_c;
      one_hot_d   = OHW'(1) << map_sel_c;
    end else if (accept_c || out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // A new trap outranks a same-cycle clear
    if (accept_c && illegal_c) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      one_hot_q   <= '0;
      err_pulse_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      one_hot_q   <= one_hot_d;
      err_pulse_q <= err_pulse_d;
      sticky_q    <= sticky_d;
    end
  end

  assign in_ready_c_o    = in_ready_c;
  assign illegal_acc_c_o = accept_c & illegal_c;
  assign out_valid_o     = out_valid_q;
  assign out_sel_o       = sel_q;
  assign out_one_hot_o   = one_hot_q;
  assign err_illegal_o   = err_pulse_q;
  assign err_sticky_o    = sticky_q;

endmodule : port_sel_remap_vc_lane

// File: rtl/port_sel_remap_vc.sv
// Multi-lane registered port-number to crossbar-select remap for the VC router.
// Optional PORT_SEL_ERR_CNT_EN builds a saturating illegal-request counter.
module port_sel_remap_vc
  import port_sel_remap_vc_pkg::*;
#(
  parameter int unsigned PORT_NUM        = 5,
  parameter int unsigned VC_NUM_PER_PORT = 2,
  parameter int unsigned SWITCH_LOCATION = 0,
  parameter int unsigned ERR_CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  port_sel_remap_vc_if.slave   bus
);

  localparam int unsigned PNW = port_num_w(PORT_NUM);
  localparam int unsigned PSW = port_sel_w(PORT_NUM);
  localparam int unsigned OHW = PORT_NUM - 1;

  if (PORT_NUM < 2) begin : g_bad_port_num
    $error("port_sel_remap_vc: PORT_NUM must be at least 2");
  end
  if (SWITCH_LOCATION >= PORT_NUM) begin : g_bad_switch_loc
    $error("port_sel_remap_vc: SWITCH_LOCATION must be below PORT_NUM");
  end

  logic [VC_NUM_PER_PORT-1:0]     in_ready_c;
  logic [VC_NUM_PER_PORT-1:0]     illegal_acc_c;
  logic [VC_NUM_PER_PORT-1:0]     out_valid;
  logic [VC_NUM_PER_PORT*PSW-1:0] out_sel;
  logic [VC_NUM_PER_PORT*OHW-1:0] out_one_hot;
  logic [VC_NUM_PER_PORT-1:0]     err_illegal;
  logic [VC_NUM_PER_PORT-1:0]     err_sticky;

  for (genvar g = 0; g < VC_NUM_PER_PORT; g++) begin : g_lane
    port_sel_remap_vc_lane #(
      .PORT_NUM        (PORT_NUM),
      .SWITCH_LOCATION (SWITCH_LOCATION)
    ) u_lane (
      .clk             (clk),
      .reset           (reset),
      .in_valid_i      (bus.in_valid[g]),
      .in_port_i       (bus.in_port_num_bcd[g*PNW +: PNW]),
      .out_ready_i     (bus.out_ready[g]),
      .err_clr_i       (bus.err_clr),
      .in_ready_c_o    (in_ready_c[g]),
      .illegal_acc_c_o (illegal_acc_c[g]),
      .out_valid_o     (out_valid[g]),
      .out_sel_o       (out_sel[g*PSW +: PSW]),
      .out_one_hot_o   (out_one_hot[g*OHW +: OHW]),
      .err_illegal_o   (err_illegal[g]),
      .err_sticky_o    (err_sticky[g])
    );
  end

  assign bus.in_ready             = in_ready_c;
  assign bus.out_valid            = out_valid;
  assign bus.out_port_sel_bcd     = out_sel;
  assign bus.out_port_sel_one_hot = out_one_hot;
  assign bus.err_illegal          = err_illegal;
  assign bus.err_sticky           = err_sticky;

`ifdef PORT_SEL_ERR_CNT_EN
  localparam int unsigned POPW = clog2_min1(VC_NUM_PER_PORT + 1);
  localparam int unsigned SUMW = ERR_CNT_WIDTH + POPW;

  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [POPW-1:0]          pop_c;
  logic [SUMW-1:0]          sum_c;

  // Count lands on the same edge as the err_illegal pulses it reflects
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(VC_NUM_PER_PORT); i++) begin
      pop_c = pop_c + POPW'(illegal_acc_c[i]);
    end
    sum_c     = SUMW'(err_cnt_q) + SUMW'(pop_c);
    err_cnt_d = (sum_c > SUMW'({ERR_CNT_WIDTH{1'b1}})) ? {ERR_CNT_WIDTH{1'b1}}
                                                         : ERR_CNT_WIDTH'(sum_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_illegal_acc;
  assign unused_illegal_acc = ^illegal_acc_c;
  assign bus.err_cnt        = '0;
`endif

endmodule : port_sel_remap_vc

// File: tb/tb_port_sel_remap_vc.sv
// Randomized + directed bench for port_sel_remap_vc against a per-lane
// behavioural model (PORT_NUM=5, SWITCH_LOCATION=2, 2 lanes, 2-bit counter).
module tb_port_sel_remap_vc;
  import port_sel_remap_vc_pkg::*;

  localparam int unsigned PN  = 5;
  localparam int unsigned VC  = 2;
  localparam int unsigned SL  = 2;
  localparam int unsigned ECW = 2;
  localparam int unsigned PNW = port_num_w(PN);
  localparam int unsigned PSW = port_sel_w(PN);
  localparam int unsigned OHW = PN - 1;
  localparam int          CNT_MAX = (1 << ECW) - 1;

  logic clk;
  logic reset;

  port_sel_remap_vc_if #(
    .PORT_NUM(PN), .VC_NUM_PER_PORT(VC), .ERR_CNT_WIDTH(ECW)
  ) bus_if ();

  port_sel_remap_vc #(
    .PORT_NUM(PN), .VC_NUM_PER_PORT(VC), .SWITCH_LOCATION(SL), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state per lane
  bit m_valid  [VC];
  int m_sel    [VC];
  int m_hot    [VC];
  bit m_pulse  [VC];
  bit m_sticky [VC];
  int m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(VC); i++) begin
      m_valid[i] = 0; m_sel[i] = 0; m_hot[i] = 0; m_pulse[i] = 0; m_sticky[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < int'(VC); i++) begin
      check_eq($sformatf("out_valid[%0d]", i), 32'(bus_if.out_valid[i]), 32'(m_valid[i]));
      check_eq($sformatf("sel_bcd[%0d]", i), 32'(bus_if.out_port_sel_bcd[i*PSW +: PSW]), 32'(m_sel[i]));
      check_eq($sformatf("one_hot[%0d]", i), 32'(bus_if.out_port_sel_one_hot[i*OHW +: OHW]), 32'(m_hot[i]));
      check_eq($sformatf("err_illegal[%0d]", i), 32'(bus_if.err_illegal[i]), 32'(m_pulse[i]));
      check_eq($sformatf("err_sticky[%0d]", i), 32'(bus_if.err_sticky[i]), 32'(m_sticky[i]));
    end
    check_eq("err_cnt", 32'(bus_if.err_cnt), 32'(m_cnt));
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check after posedge
  task automatic drive_cycle(input logic [VC-1:0] iv, input int p0, input int p1,
                             input logic [VC-1:0] ordy, input logic clr);
    int  p;
    int  n_ill;
    bit  rdy, acc, ill;
    @(negedge clk);
    reset = 1'b0;
    bus_if.in_valid        = iv;
    bus_if.in_port_num_bcd = {PNW'(p1), PNW'(p0)};
    bus_if.out_ready       = ordy;
    bus_if.err_clr         = clr;
    #1;
    n_ill = 0;
    for (int i = 0; i < int'(VC); i++) begin
      p   = (i == 0) ? p0 : p1;
      rdy = !m_valid[i] || ordy[i];
      check_eq($sformatf("in_ready[%0d]", i), 32'(bus_if.in_ready[i]), 32'(rdy));
      acc = iv[i] && rdy;
      ill = (p == int'(SL)) || (p >= int'(PN));
      m_pulse[i] = acc && ill;
      if (acc && !ill) begin
        m_valid[i] = 1;
        m_sel[i]   = (p > int'(SL)) ? p - 1 : p;
        m_hot[i]   = 1 << m_sel[i];
      end else if (acc || ordy[i]) begin
        m_valid[i] = 0;
      end
      if (acc && ill) begin
        m_sticky[i] = 1;
        n_ill++;
      end else if (clr) begin
        m_sticky[i] = 0;
      end
    end
`ifdef PORT_SEL_ERR_CNT_EN
    m_cnt = (m_cnt + n_ill > CNT_MAX) ? CNT_MAX : m_cnt + n_ill;
`endif
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_if.in_valid  = '0;
    bus_if.out_ready = '0;
    bus_if.err_clr   = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < int'(VC); i++)
      check_eq($sformatf("rst_in_ready[%0d]", i), 32'(bus_if.in_ready[i]), 32'd1);
  endtask

  initial begin
    int exp_sel[4];
    int ports[4];
    exp_sel = '{0, 1, 2, 3};
    ports   = '{0, 1, 3, 4};
    reset = 1'b1;
    bus_if.in_valid = '0;
    bus_if.in_port_num_bcd = '0;
    bus_if.out_ready = '0;
    bus_if.err_clr = 1'b0;
    model_reset();
    do_reset();

    // Lane0 back-to-back legal ports, no bubbles
    for (int k = 0; k < 4; k++) begin
      drive_cycle(2'b01, ports[k], 0, 2'b11, 1'b0);
      check_eq("dir_sel", 32'(bus_if.out_port_sel_bcd[0 +: PSW]), 32'(exp_sel[k]));
      check_eq("dir_valid", 32'(bus_if.out_valid[0]), 32'd1);
    end
    drive_cycle(2'b00, 0, 0, 2'b11, 1'b0);

    // Lane1 U-turn, then clear
    drive_cycle(2'b10, 0, int'(SL), 2'b11, 1'b0);
    check_eq("uturn_pulse", 32'(bus_if.err_illegal[1]), 32'd1);
    drive_cycle(2'b00, 0, 0, 2'b11, 1'b0);
    check_eq("uturn_sticky", 32'(bus_if.err_sticky[1]), 32'd1);
    drive_cycle(2'b00, 0, 0, 2'b11, 1'b1);
    check_eq("clr_sticky", 32'(bus_if.err_sticky[1]), 32'd0);

    // Backpressure hold with sel=2 stable
    drive_cycle(2'b01, 3, 0, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(2'b01, 4, 0, 2'b00, 1'b0);
      check_eq("hold_sel", 32'(bus_if.out_port_sel_bcd[0 +: PSW]), 32'd2);
    end
    drive_cycle(2'b01, 4, 0, 2'b01, 1'b0);
    check_eq("release_sel", 32'(bus_if.out_port_sel_bcd[0 +: PSW]), 32'd3);

    // Both lanes out of range, repeated to saturate the counter
    for (int k = 0; k < 3; k++) drive_cycle(2'b11, 7, 7, 2'b11, 1'b0);

    // Illegal accept together with clear keeps sticky set
    drive_cycle(2'b01, 2, 0, 2'b11, 1'b1);
    check_eq("clr_vs_set", 32'(bus_if.err_sticky[0]), 32'd1);

    // Reset while a result is held
    drive_cycle(2'b11, 1, 4, 2'b00, 1'b0);
    do_reset();

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        drive_cycle(VC'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    VC'($urandom | $urandom), ($urandom_range(0, 7) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_port_sel_remap_vc
